// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: memory-stage controller placed ahead of the load extractor.
// Accepts one load/store from execute, issues it to data memory over a
// valid/ready port, waits for the variable-latency load response and hands
// the raw word, byte address and funct3 downstream. Stalls the pipe while busy.
//
// Configuration macro: MEM_MISALIGN_TRAP_EN
//   defined   -> misaligned halfword/word ops skip memory and end with err
//   undefined -> misaligned ops are issued with the normal lane rules
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   req_*                  op from execute (valid/ready, store flag, addr, funct3, wdata)
//   stall                  pipeline hold
//   dmem_req_*/dmem_addr/
//   dmem_we/dmem_din       request to data memory (held stable until ready)
//   dmem_resp_valid/_data  load response from data memory
//   resp_valid/resp_is_load completion pulse and its qualifier
//   mem_address/mem_output/
//   funct3                 latched byte address, raw word, latched funct3
//   err                    one-cycle error pulse (timeout or misaligned trap)
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_wdata,
    output logic              stall,
    output logic              dmem_req_valid,
    input  logic              dmem_req_ready,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [3:0]        dmem_we,
    output logic [31:0]       dmem_din,
    input  logic              dmem_resp_valid,
    input  logic [31:0]       dmem_resp_data,
    output logic              resp_valid,
    output logic              resp_is_load,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_output,
    output logic [2:0]        funct3,
    output logic              err
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned LIMIT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_store;
    logic [ADDR_W-1:0]  r_addr;
    logic [2:0]         r_funct3;
    logic [ADDR_W-1:0]  r_dmem_addr;
    logic [3:0]         r_dmem_we;
    logic [31:0]        r_dmem_din;
    logic [31:0]        r_mem_output;
    logic               r_err;

    logic               w_accept;
    logic               w_capture;
    logic               w_err_next;
    logic               w_misalign;
    logic               w_limit;
    logic [3:0]         w_we;
    logic [31:0]        w_din;

    // Misalignment only matters when the trap is built in
`ifdef MEM_MISALIGN_TRAP_EN
    assign w_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                        ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    // Timeout limit reached in WAIT; a zero TIMEOUT_CYCLES disables it
    assign w_limit = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_W'(LIMIT));

    // Store lane steering from funct3 and the byte offset
    always_comb begin
        w_we  = 4'b1111;
        w_din = req_wdata;
        case (req_funct3)
            3'b000: begin
                w_we  = 4'b0001 << req_addr[1:0];
                w_din = {4{req_wdata[7:0]}};
            end
            3'b001: begin
                case (req_addr[1:0])
                    2'b00: begin
                        w_we  = 4'b0011;
                        w_din = {16'h0000, req_wdata[15:0]};
                    end
                    2'b01: begin
                        w_we  = 4'b0110;
                        w_din = {8'h00, req_wdata[15:0], 8'h00};
                    end
                    default: begin
                        w_we  = 4'b1100;
                        w_din = {req_wdata[15:0], 16'h0000};
                    end
                endcase
            end
            default: ;
        endcase
    end

    // Next-state and handshake outputs
    always_comb begin
        w_next         = r_state;
        w_accept       = 1'b0;
        w_capture      = 1'b0;
        w_err_next     = 1'b0;
        req_ready      = 1'b0;
        stall          = 1'b1;
        dmem_req_valid = 1'b0;
        resp_valid     = 1'b0;
        resp_is_load   = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                stall     = req_valid;
                if (req_valid) begin
                    w_accept   = 1'b1;
                    w_err_next = w_misalign;
                    w_next     = w_misalign ? S_RESP : S_REQ;
                end
            end
            S_REQ: begin
                dmem_req_valid = 1'b1;
                if (dmem_req_ready) begin
                    if (r_store) begin
                        // Store completes on the handshake itself
                        resp_valid = 1'b1;
                        w_next     = S_IDLE;
                    end else begin
                        w_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // Response beats the timeout when both land together
                if (dmem_resp_valid) begin
                    w_capture = 1'b1;
                    w_next    = S_RESP;
                end else if (w_limit) begin
                    w_err_next = 1'b1;
                    w_next     = S_RESP;
                end
            end
            S_RESP: begin
                resp_valid   = 1'b1;
                resp_is_load = ~r_store;
                w_next       = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State, latched request fields and response data
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_store      <= 1'b0;
            r_addr       <= '0;
            r_funct3     <= '0;
            r_dmem_addr  <= '0;
            r_dmem_we    <= '0;
            r_dmem_din   <= '0;
            r_mem_output <= '0;
            r_err        <= 1'b0;
        end else begin
            r_state <= w_next;
            r_err   <= w_err_next;
            r_cnt   <= (r_state == S_WAIT) ? r_cnt + CNT_W'(1) : '0;
            if (w_accept) begin
                r_store     <= req_store;
                r_addr      <= req_addr;
                r_funct3    <= req_funct3;
                r_dmem_addr <= {req_addr[ADDR_W-1:2], 2'b00};
                r_dmem_we   <= req_store ? w_we : 4'b0000;
                r_dmem_din  <= w_din;
            end
            if (w_capture) begin
                r_mem_output <= dmem_resp_data;
            end else if (w_err_next) begin
                r_mem_output <= '0;
            end
        end
    end

    assign dmem_addr   = r_dmem_addr;
    assign dmem_we     = r_dmem_we;
    assign dmem_din    = r_dmem_din;
    assign mem_address = r_addr;
    assign mem_output  = r_mem_output;
    assign funct3      = r_funct3;
    assign err         = r_err;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl (TIMEOUT_CYCLES = 8).
module tb_mem_access_ctrl;

    localparam int TO = 8;
`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit MISALIGN_EN = 1'b1;
`else
    localparam bit MISALIGN_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_store;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic [31:0] req_wdata;
    logic        stall;
    logic        dmem_req_valid, dmem_req_ready;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_we;
    logic [31:0] dmem_din;
    logic        dmem_resp_valid;
    logic [31:0] dmem_resp_data;
    logic        resp_valid, resp_is_load;
    logic [31:0] mem_address, mem_output;
    logic [2:0]  funct3;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    // Observations from the last run_op
    logic        o_saw_req, o_stable, o_stall_ok, o_acc_ready, o_post_ready, o_timed_out;
    logic        o_is_load, o_err;
    int          o_req_cycles, o_resp_cycle, o_resp_count, o_err_count;
    logic [31:0] o_daddr, o_din, o_mout, o_maddr;
    logic [3:0]  o_we;
    logic [2:0]  o_f3;

    mem_access_ctrl #(.TIMEOUT_CYCLES(TO), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
        .stall(stall),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_din(dmem_din),
        .dmem_resp_valid(dmem_resp_valid), .dmem_resp_data(dmem_resp_data),
        .resp_valid(resp_valid), .resp_is_load(resp_is_load),
        .mem_address(mem_address), .mem_output(mem_output),
        .funct3(funct3), .err(err)
    );

    always #5 clk = ~clk;

    // Reference lane rules, written arithmetically
    function automatic logic [3:0] exp_we(input logic [2:0] f, input logic [1:0] o);
        int oo;
        oo = (o == 2'd3) ? 2 : int'(o);
        if (f == 3'd0)      return 4'(1 << o);
        else if (f == 3'd1) return 4'(3 << oo);
        else                return 4'hF;
    endfunction

    function automatic logic [31:0] exp_din(input logic [2:0] f, input logic [1:0] o, input logic [31:0] wd);
        int oo;
        oo = (o == 2'd3) ? 2 : int'(o);
        if (f == 3'd0)      return 32'(wd[7:0]) * 32'h01010101;
        else if (f == 3'd1) return 32'(wd[15:0]) << (8 * oo);
        else                return wd;
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] we);
        return {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
    endfunction

    function automatic logic is_misal(input logic [2:0] f, input logic [31:0] a);
        return ((f[1:0] == 2'b01) && a[0]) || ((f[1:0] == 2'b10) && (a[1:0] != 2'b00));
    endfunction

    // Drives one op; rd = cycles of ready back-pressure, rsd = wait cycles before
    // the response (-1 = never). Cycle 0 is the accept cycle.
    task automatic run_op(input logic st, input logic [31:0] a, input logic [2:0] f,
                          input logic [31:0] wd, input int rd, input int rsd,
                          input logic [31:0] rdata);
        int  cyc, ridx, hs;
        logic done;
        o_saw_req = 0; o_stable = 1; o_stall_ok = 1; o_timed_out = 0;
        o_req_cycles = 0; o_resp_cycle = -1; o_resp_count = 0; o_err_count = 0;
        o_is_load = 0; o_err = 0; o_mout = 0; o_maddr = 0; o_f3 = 0;
        o_daddr = 0; o_we = 0; o_din = 0;
        @(negedge clk);
        req_valid = 1; req_store = st; req_addr = a; req_funct3 = f; req_wdata = wd;
        dmem_req_ready = 0; dmem_resp_valid = 0;
        #1;
        o_acc_ready = req_ready;
        if (!stall) o_stall_ok = 0;
        if (resp_valid) o_resp_count++;
        cyc = 0; ridx = 0; hs = -1; done = 0;
        while (!done && cyc < 60) begin
            @(negedge clk);
            cyc++;
            req_valid = 0; req_store = 1'($urandom); req_addr = $urandom;
            req_funct3 = 3'($urandom); req_wdata = $urandom;
            dmem_req_ready = 0; dmem_resp_valid = 0; dmem_resp_data = $urandom;
            if (dmem_req_valid) begin
                if (!o_saw_req) begin
                    o_daddr = dmem_addr; o_we = dmem_we; o_din = dmem_din;
                end else if (dmem_addr !== o_daddr || dmem_we !== o_we || dmem_din !== o_din) begin
                    o_stable = 0;
                end
                o_saw_req = 1;
                o_req_cycles++;
                if (ridx >= rd && hs < 0) begin
                    dmem_req_ready = 1;
                    hs = cyc;
                end
                ridx++;
            end
            if (hs >= 0 && hs < cyc && rsd >= 0 && cyc == hs + 1 + rsd) begin
                dmem_resp_valid = 1; dmem_resp_data = rdata;
            end
            #1;
            if (!stall) o_stall_ok = 0;
            if (err) o_err_count++;
            if (resp_valid) begin
                o_resp_count++; o_resp_cycle = cyc; o_is_load = resp_is_load;
                o_mout = mem_output; o_maddr = mem_address; o_f3 = funct3; o_err = err;
                done = 1;
            end
        end
        if (!done) o_timed_out = 1;
        @(negedge clk);
        req_valid = 0; dmem_req_ready = 0; dmem_resp_valid = 0;
        #1;
        o_post_ready = req_ready;
        if (resp_valid) o_resp_count++;
        if (err) o_err_count++;
    endtask

    task automatic test_reset();
        rst = 1; req_valid = 0; req_store = 0; req_addr = 0; req_funct3 = 0; req_wdata = 0;
        dmem_req_ready = 0; dmem_resp_valid = 0; dmem_resp_data = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        #1;
        n_tests++;
        if (req_ready !== 1'b1 || stall !== 1'b0 || dmem_req_valid !== 1'b0 || resp_valid !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl got ready=%b stall=%b dreq=%b rv=%b err=%b exp 1 0 0 0 0",
                     req_ready, stall, dmem_req_valid, resp_valid, err);
        end
        n_tests++;
        if (mem_output !== 0 || mem_address !== 0 || funct3 !== 0 || dmem_we !== 0 || dmem_din !== 0 || dmem_addr !== 0 || resp_is_load !== 0) begin
            n_fail++;
            $display("FAIL reset_data got mout=%h maddr=%h f3=%0d we=%b din=%h daddr=%h exp all zero",
                     mem_output, mem_address, funct3, dmem_we, dmem_din, dmem_addr);
        end
    endtask

    task automatic test_load_half();
        run_op(0, 32'h1001, 3'b001, 32'h0, 0, 2, 32'hAABBCCDD);
        n_tests++;
        if (o_daddr !== 32'h1000 || o_we !== 4'b0000) begin
            n_fail++; $display("FAIL load_req got addr=%h we=%b exp 00001000 0000", o_daddr, o_we);
        end
        n_tests++;
        if (o_resp_cycle !== 5 || o_resp_count !== 1 || o_is_load !== 1'b1 || o_err !== 1'b0) begin
            n_fail++; $display("FAIL load_resp got cyc=%0d cnt=%0d isld=%b err=%b exp 5 1 1 0",
                               o_resp_cycle, o_resp_count, o_is_load, o_err);
        end
        n_tests++;
        if (o_mout !== 32'hAABBCCDD || o_maddr !== 32'h1001 || o_f3 !== 3'b001) begin
            n_fail++; $display("FAIL load_data got mout=%h maddr=%h f3=%b exp aabbccdd 00001001 001",
                               o_mout, o_maddr, o_f3);
        end
        n_tests++;
        if (o_stall_ok !== 1'b1 || o_acc_ready !== 1'b1 || o_post_ready !== 1'b1) begin
            n_fail++; $display("FAIL load_stall got stall_ok=%b acc_ready=%b post_ready=%b exp 1 1 1",
                               o_stall_ok, o_acc_ready, o_post_ready);
        end
    endtask

    task automatic test_store_byte();
        run_op(1, 32'h2003, 3'b000, 32'h12345678, 0, -1, 32'h0);
        n_tests++;
        if (o_we !== 4'b1000 || o_din !== 32'h78787878 || o_daddr !== 32'h2000) begin
            n_fail++; $display("FAIL sb_lanes got we=%b din=%h addr=%h exp 1000 78787878 00002000",
                               o_we, o_din, o_daddr);
        end
        n_tests++;
        if (o_resp_cycle !== 1 || o_is_load !== 1'b0 || o_resp_count !== 1 || o_post_ready !== 1'b1) begin
            n_fail++; $display("FAIL sb_resp got cyc=%0d isld=%b cnt=%0d post_ready=%b exp 1 0 1 1",
                               o_resp_cycle, o_is_load, o_resp_count, o_post_ready);
        end
    endtask

    task automatic test_store_half_backpressure();
        run_op(1, 32'h2001, 3'b001, 32'h0000BEEF, 3, -1, 32'h0);
        n_tests++;
        if (o_we !== 4'b0110 || o_din[23:8] !== 16'hBEEF) begin
            n_fail++; $display("FAIL sh_lanes got we=%b din=%h exp 0110 xxBEEFxx", o_we, o_din);
        end
        n_tests++;
        if (o_req_cycles !== 4 || o_stable !== 1'b1 || o_stall_ok !== 1'b1 || o_resp_cycle !== 4) begin
            n_fail++; $display("FAIL sh_hold got reqcyc=%0d stable=%b stall_ok=%b cyc=%0d exp 4 1 1 4",
                               o_req_cycles, o_stable, o_stall_ok, o_resp_cycle);
        end
    endtask

    task automatic test_timeout();
        run_op(0, 32'h0500, 3'b010, 32'h0, 0, -1, 32'h0);
        n_tests++;
        if (o_resp_cycle !== 2 + TO || o_err !== 1'b1 || o_err_count !== 1 || o_mout !== 32'h0) begin
            n_fail++; $display("FAIL timeout got cyc=%0d err=%b errcnt=%0d mout=%h exp %0d 1 1 0",
                               o_resp_cycle, o_err, o_err_count, o_mout, 2 + TO);
        end
        run_op(0, 32'h0504, 3'b010, 32'h0, 1, 0, 32'h5A5A1234);
        n_tests++;
        if (o_resp_cycle !== 4 || o_err_count !== 0 || o_mout !== 32'h5A5A1234 || o_acc_ready !== 1'b1) begin
            n_fail++; $display("FAIL after_timeout got cyc=%0d errcnt=%0d mout=%h ready=%b exp 4 0 5a5a1234 1",
                               o_resp_cycle, o_err_count, o_mout, o_acc_ready);
        end
    endtask

    task automatic test_coincide();
        run_op(0, 32'h0600, 3'b010, 32'h0, 0, TO - 1, 32'hCAFEF00D);
        n_tests++;
        if (o_resp_cycle !== 2 + TO || o_err_count !== 0 || o_mout !== 32'hCAFEF00D) begin
            n_fail++; $display("FAIL coincide got cyc=%0d errcnt=%0d mout=%h exp %0d 0 cafef00d",
                               o_resp_cycle, o_err_count, o_mout, 2 + TO);
        end
    endtask

    task automatic test_mid_reset();
        logic bad_rv, bad_rdy;
        bad_rv = 0; bad_rdy = 0;
        @(negedge clk);
        req_valid = 1; req_store = 0; req_addr = 32'h40; req_funct3 = 3'b010;
        @(negedge clk);
        req_valid = 0; dmem_req_ready = 1;
        @(negedge clk);
        dmem_req_ready = 0;
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0; dmem_resp_valid = 1; dmem_resp_data = 32'hDEADBEEF;
        #1;
        n_tests++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_ready got ready=%b rv=%b exp 1 0", req_ready, resp_valid);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            if (resp_valid !== 1'b0) bad_rv = 1;
            if (req_ready !== 1'b1 || mem_output !== 32'h0) bad_rdy = 1;
        end
        dmem_resp_valid = 0;
        n_tests++;
        if (bad_rv !== 1'b0 || bad_rdy !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_stale got stray_rv=%b bad_idle=%b exp 0 0", bad_rv, bad_rdy);
        end
    endtask

    task automatic test_misalign();
        int       exp_cyc;
        logic     exp_err, exp_saw;
        logic [31:0] exp_mout;
        run_op(0, 32'h3002, 3'b010, 32'h0, 0, 0, 32'h13572468);
        exp_saw  = !MISALIGN_EN;
        exp_cyc  = MISALIGN_EN ? 1 : 3;
        exp_err  = MISALIGN_EN;
        exp_mout = MISALIGN_EN ? 32'h0 : 32'h13572468;
        n_tests++;
        if (o_saw_req !== exp_saw || o_resp_cycle !== exp_cyc || o_err !== exp_err || o_mout !== exp_mout) begin
            n_fail++; $display("FAIL misalign_lw got dreq=%b cyc=%0d err=%b mout=%h exp %b %0d %b %h",
                               o_saw_req, o_resp_cycle, o_err, o_mout, exp_saw, exp_cyc, exp_err, exp_mout);
        end
    endtask

    task automatic test_random();
        logic [2:0]  load_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        logic        st, trap, to, x_err, x_load;
        logic [31:0] a, wd, rdata, x_mout, m;
        logic [2:0]  f;
        int          rd, rsd, x_cyc;
        for (int i = 0; i < 30; i++) begin
            st    = 1'($urandom);
            a     = $urandom;
            wd    = $urandom;
            rdata = $urandom;
            f     = st ? 3'($urandom_range(0, 7)) : load_f3[$urandom_range(0, 4)];
            rd    = $urandom_range(0, 3);
            rsd   = int'($urandom_range(0, 10)) - 1;
            run_op(st, a, f, wd, rd, rsd, rdata);
            trap   = MISALIGN_EN && is_misal(f, a);
            to     = !st && (rsd < 0 || rsd >= TO);
            x_load = !st;
            if (trap) begin
                x_cyc = 1; x_err = 1; x_mout = 0;
            end else if (st) begin
                x_cyc = 1 + rd; x_err = 0; x_mout = o_mout;
            end else begin
                x_cyc = to ? 2 + rd + TO : 3 + rd + rsd; x_err = to; x_mout = to ? 32'h0 : rdata;
            end
            n_tests++;
            if (o_timed_out !== 1'b0 || o_resp_cycle !== x_cyc || o_resp_count !== 1 || o_is_load !== x_load) begin
                n_fail++; $display("FAIL rnd%0d_resp got cyc=%0d cnt=%0d isld=%b hang=%b exp %0d 1 %b 0",
                                   i, o_resp_cycle, o_resp_count, o_is_load, o_timed_out, x_cyc, x_load);
            end
            n_tests++;
            if (o_err !== x_err || o_err_count !== int'(x_err) || o_mout !== x_mout) begin
                n_fail++; $display("FAIL rnd%0d_data got err=%b errcnt=%0d mout=%h exp %b %0d %h",
                                   i, o_err, o_err_count, o_mout, x_err, int'(x_err), x_mout);
            end
            n_tests++;
            if (o_maddr !== a || o_f3 !== f || o_stall_ok !== 1'b1 || o_post_ready !== 1'b1) begin
                n_fail++; $display("FAIL rnd%0d_latch got maddr=%h f3=%0d stall_ok=%b post_ready=%b exp %h %0d 1 1",
                                   i, o_maddr, o_f3, o_stall_ok, o_post_ready, a, f);
            end
            if (!trap) begin
                m = st ? ((f == 3'd1) ? lane_mask(exp_we(f, a[1:0])) : 32'hFFFFFFFF) : 32'h0;
                n_tests++;
                if (o_saw_req !== 1'b1 || o_req_cycles !== rd + 1 || o_stable !== 1'b1 ||
                    o_daddr !== {a[31:2], 2'b00} || o_we !== (st ? exp_we(f, a[1:0]) : 4'b0000) ||
                    (o_din & m) !== (exp_din(f, a[1:0], wd) & m)) begin
                    n_fail++; $display("FAIL rnd%0d_req got reqcyc=%0d stable=%b addr=%h we=%b din=%h exp %0d 1 %h %b %h",
                                       i, o_req_cycles, o_stable, o_daddr, o_we, o_din, rd + 1,
                                       {a[31:2], 2'b00}, st ? exp_we(f, a[1:0]) : 4'b0000, exp_din(f, a[1:0], wd));
                end
            end else begin
                n_tests++;
                if (o_saw_req !== 1'b0) begin
                    n_fail++; $display("FAIL rnd%0d_trap got dreq=%b exp 0", i, o_saw_req);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_half();
        test_store_byte();
        test_store_half_backpressure();
        test_timeout();
        test_coincide();
        test_mid_reset();
        test_misalign();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
